md_hilo_unit: RTL and testbench
===============================

// Module: md_hilo_unit
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, in the E stage.
//   Runs mult/multu/div/divu and the accumulate ops madd/maddu/msub/msubu.
//   Executes mthi/mtlo/mfhi/mflo and drives a stall signal to the hazard unit.
//   Latencies are configurable. An interrupt request suppresses new side effects but never aborts a committed op.
// PARAMETERS
//   WIDTH    32  operand / HI / LO width in bits (>=8)
//   MUL_LAT  5   busy cycles for mult/multu/madd*/msub* (>=1)
//   DIV_LAT  10  busy cycles for div/divu (>=1)
// PORTS
//   clk      in   1      clock; all state changes on posedge
//   reset    in   1      synchronous, active-high; clears all state
//   req      in   1      interrupt/exception request: the op presented this cycle is dropped
//   op       in   4      operation code (encoding below); 0 = none
//   rs       in   WIDTH  operand A (dividend / multiplicand / mthi,mtlo source)
//   rt       in   WIDTH  operand B (divisor / multiplier)
//   busy     out  1      start | busy_q; the pipeline stalls on this
//   done     out  1      1-cycle pulse in the final busy cycle of an op
//   rdata    out  WIDTH  mfhi -> HI, mflo -> LO, else 0 (combinational)
// BEHAVIOUR
//   Op encoding:
//     0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo,
//     9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 behave as none.
//   start = op in {1,2,3,4,9..12}, combinational; asserted even when req=1.
//   busy = start | busy_q.
//   Reset: HI=0, LO=0, cnt=0, busy_q=0, temps=0; busy=start, done=0, rdata per op.
//   Issue is accepted at a posedge when !reset & !req & cnt==0:
//     - mult/madd/msub (signed) and multu/maddu/msubu (unsigned):
//         tmp <= 2*WIDTH product; cnt <= MUL_LAT; busy_q <= 1.
//     - div/divu: tmp_lo <= quotient (truncated toward 0); tmp_hi <= remainder (sign of dividend);
//         cnt <= DIV_LAT; busy_q <= 1.
//     - mthi/mtlo: HI or LO <= rs at that edge; no busy.
//   Countdown: each edge with cnt>1 does cnt <= cnt-1. The edge with cnt==1 commits, then cnt<=0, busy_q<=0.
//   Timing: an op issued at the end of cycle T is busy in cycles T+1..T+LAT.
//     done=1 in cycle T+LAT. The new HI/LO are visible in cycle T+LAT+1.
//   Commit values:
//     - mult*/div*: {HI,LO} <= tmp.
//     - madd*: {HI,LO} <= {HI,LO} + tmp.
//     - msub*: {HI,LO} <= {HI,LO} - tmp.
//     - All 2*WIDTH-bit, modulo 2^(2*WIDTH).
//   Divide by zero (rt==0): completes with the full DIV_LAT busy time, but HI/LO are left unchanged.
//   Signed overflow (rs = most-negative, rt = -1): LO <= most-negative, HI <= 0; no trap.
//   While cnt!=0, any op (including mthi/mtlo) is ignored. Upstream holds the op because busy=1.
//   mfhi/mflo while busy_q: rdata returns the current (old) HI/LO. The stall prevents use.
//   req=1:
//     - the op presented this cycle is dropped (no issue, no mthi/mtlo write);
//     - an in-flight op continues and commits on schedule;
//     - req during the commit edge does not block the commit.
//   Reset has priority over everything. Reset mid-op aborts: cnt=0, busy_q=0, HI=LO=0, no done pulse.
// TESTING
//   mult rs=-3 rt=5 -> busy for 5 cycles, done in cycle 5; then HI=FFFFFFFF, LO=FFFFFFF1.
//   div rs=-7 rt=2 -> after 10 busy cycles LO=FFFFFFFD, HI=FFFFFFFF. divu 7/2 -> LO=3, HI=1.
//   mthi 0, mtlo 10, then madd rs=2 rt=3 -> LO=00000010, HI=0. msub rs=1 rt=0x20 -> LO=FFFFFFF0, HI=FFFFFFFF.
//   div rt=0 after mtlo 5 -> 10 busy cycles, LO still 5. div 80000000/FFFFFFFF -> LO=80000000, HI=0.
//   mult with req=1 in the issue cycle -> busy=1 that cycle only, HI/LO unchanged. req mid-op -> commit still occurs.
//   reset in busy cycle 3 of a div -> next cycle busy=0, HI=LO=0, no done pulse; mfhi then returns 0.

Source files
------------

// File: rtl/md_hilo_unit.sv
// md_hilo_unit: multi-cycle mult/div/madd/msub unit with HI/LO registers and stall output
module md_hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata
);
  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAXL + 1);
  localparam logic [1:0] K_SET = 2'd0, K_ADD = 2'd1, K_SUB = 2'd2, K_NONE = 2'd3;
  logic [WIDTH-1:0]   hi, lo, ua, ub, uq, ur, q, r;
  logic [CW-1:0]      cnt;
  logic               busy_q, is_mul, is_div, sgn, start, na, nb;
  logic [1:0]         kind, next_kind;
  logic [2*WIDTH-1:0] tmp, prod, acc, ma, mb;
  always_comb begin
    is_mul = op inside {4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12};
    is_div = op inside {4'd3, 4'd4};
    start  = is_mul | is_div;
    sgn    = op inside {4'd1, 4'd3, 4'd9, 4'd11};
    na     = sgn & rs[WIDTH-1];
    nb     = sgn & rt[WIDTH-1];
    ma     = {{WIDTH{na}}, rs};
    mb     = {{WIDTH{nb}}, rt};
    prod   = ma * mb;
    // Divide on magnitudes so the most-negative / -1 case wraps cleanly
    ua     = na ? -rs : rs;
    ub     = nb ? -rt : rt;
    uq     = (ub == '0) ? '0 : ua / ub;
    ur     = (ub == '0) ? '0 : ua % ub;
    q      = (na ^ nb) ? -uq : uq;
    r      = na ? -ur : ur;
    next_kind = is_div ? ((rt == '0) ? K_NONE : K_SET) :
                (op inside {4'd9, 4'd10}) ? K_ADD :
                (op inside {4'd11, 4'd12}) ? K_SUB : K_SET;
    acc    = (kind == K_ADD) ? {hi, lo} + tmp : (kind == K_SUB) ? {hi, lo} - tmp : tmp;
    busy   = start | busy_q;
    done   = (cnt == CW'(1));
    rdata  = (op == 4'd7) ? hi : (op == 4'd8) ? lo : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      tmp    <= '0;
      kind   <= K_SET;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy_q <= 1'b0;
        if (kind != K_NONE) {hi, lo} <= acc;
      end
    end else if (!req) begin
      if (start) begin
        cnt    <= is_mul ? CW'(MUL_LAT) : CW'(DIV_LAT);
        busy_q <= 1'b1;
        tmp    <= is_mul ? prod : {r, q};
        kind   <= next_kind;
      end else if (op == 4'd5) hi <= rs;
      else if (op == 4'd6) lo <= rs;
    end
  end
endmodule

// File: tb/tb_md_hilo_unit.sv
// tb_md_hilo_unit: directed vector table plus hand sequences for req, busy-ignore and reset abort
module tb_md_hilo_unit;
  logic        clk = 1'b0, reset = 1'b1, req = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs = '0, rt = '0;
  logic        busy, done;
  logic [31:0] rdata;
  int checks = 0, failures = 0;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] hi, lo;
    string       name;
  } vec_t;
  vec_t v[16];
  md_hilo_unit dut (.clk(clk), .reset(reset), .req(req), .op(op), .rs(rs), .rt(rt),
                    .busy(busy), .done(done), .rdata(rdata));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
    @(posedge clk); #1 op = 4'd7;
    @(negedge clk); h = rdata;
    @(posedge clk); #1 op = 4'd8;
    @(negedge clk); l = rdata;
    op = 4'd0;
  endtask
  task automatic run(input vec_t t);
    int nbusy, dpos;
    logic [31:0] h, l;
    @(posedge clk); #1 op = t.op; rs = t.a; rt = t.b;
    @(negedge clk); chk({t.name, " issue_busy"}, 32'(busy), 32'(t.lat > 0));
    @(posedge clk); #1 op = 4'd0;
    nbusy = 0; dpos = 0;
    for (int i = 1; i <= t.lat + 2; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) dpos = (dpos == 0) ? i : -1;
    end
    chk({t.name, " busy_cycles"}, nbusy, t.lat);
    chk({t.name, " done_cycle"}, dpos, t.lat);
    read_hl(h, l);
    chk({t.name, " hi"}, h, t.hi);
    chk({t.name, " lo"}, l, t.lo);
  endtask
  initial begin
    logic [31:0] h, l;
    int nd;
    v[0]  = '{4'd1,  32'hFFFFFFFD, 32'd5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5"};
    v[1]  = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, "multu_max"};
    v[2]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"};
    v[3]  = '{4'd4,  32'd7,        32'd2,        10, 32'd1,        32'd3,        "divu_7_2"};
    v[4]  = '{4'd5,  32'd0,        32'd0,        0,  32'd0,        32'd3,        "mthi_0"};
    v[5]  = '{4'd6,  32'd10,       32'd0,        0,  32'd0,        32'd10,       "mtlo_10"};
    v[6]  = '{4'd9,  32'd2,        32'd3,        5,  32'd0,        32'h00000010, "madd_2x3"};
    v[7]  = '{4'd11, 32'd1,        32'h20,       5,  32'hFFFFFFFF, 32'hFFFFFFF0, "msub_1x20"};
    v[8]  = '{4'd10, 32'hFFFFFFFF, 32'd2,        5,  32'd1,        32'hFFFFFFEE, "maddu_carry"};
    v[9]  = '{4'd12, 32'd1,        32'd1,        5,  32'd1,        32'hFFFFFFED, "msubu_1x1"};
    v[10] = '{4'd6,  32'd5,        32'd0,        0,  32'd1,        32'd5,        "mtlo_5"};
    v[11] = '{4'd3,  32'd9,        32'd0,        10, 32'd1,        32'd5,        "div_by_zero"};
    v[12] = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 10, 32'd0,        32'h80000000, "div_overflow"};
    v[13] = '{4'd9,  32'hFFFFFFFF, 32'd2,        5,  32'd0,        32'h7FFFFFFE, "madd_signed"};
    v[14] = '{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'd0,        32'h7FFFFFFD, "msub_signed"};
    v[15] = '{4'd3,  32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD, "div_7_neg2"};
    // reset state; start still raises busy while in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    op = 4'd1;
    #1 chk("reset_busy_start", 32'(busy), 32'd1);
    @(posedge clk); #1 op = 4'd0; reset = 1'b0;
    @(negedge clk); chk("reset_no_issue", 32'(busy), 32'd0);
    read_hl(h, l);
    chk("reset_hi", h, 32'd0);
    chk("reset_lo", l, 32'd0);
    for (int i = 0; i < 16; i++) run(v[i]);
    // req in the issue cycle: busy only that cycle, nothing issued
    @(posedge clk); #1 req = 1'b1; op = 4'd1; rs = 32'd3; rt = 32'd3;
    @(negedge clk); chk("req_issue_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 req = 1'b0; op = 4'd0;
    nd = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (busy | done) nd++;
    end
    chk("req_drop_idle", nd, 0);
    read_hl(h, l);
    chk("req_drop_hi", h, 32'd1);
    chk("req_drop_lo", l, 32'hFFFFFFFD);
    // req mid-op: commit still happens; mtlo under req is dropped
    @(posedge clk); #1 op = 4'd1; rs = 32'd2; rt = 32'd3;
    @(posedge clk); #1 op = 4'd0;
    @(posedge clk); #1 req = 1'b1; op = 4'd6; rs = 32'd99;
    @(negedge clk); @(negedge clk);
    chk("req_mid_done_c3", 32'(done), 32'd0);
    @(negedge clk); @(negedge clk);
    chk("req_mid_done_c5", 32'(done), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1 req = 1'b0; op = 4'd0;
    read_hl(h, l);
    chk("req_mid_hi", h, 32'd0);
    chk("req_mid_lo", l, 32'd6);
    // mtlo presented while busy is ignored
    @(posedge clk); #1 op = 4'd4; rs = 32'd9; rt = 32'd4;
    @(posedge clk); #1 op = 4'd0;
    @(posedge clk); #1 op = 4'd6; rs = 32'd77;
    @(posedge clk); #1 op = 4'd0;
    repeat (10) @(posedge clk);
    read_hl(h, l);
    chk("busy_ignore_hi", h, 32'd1);
    chk("busy_ignore_lo", l, 32'd2);
    // reset in busy cycle 3 of a div aborts without a done pulse
    @(posedge clk); #1 op = 4'd3; rs = 32'd100; rt = 32'd7;
    @(posedge clk); #1 op = 4'd0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); chk("abort_busy_c3", 32'(busy), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); chk("abort_busy_after", 32'(busy), 32'd0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    read_hl(h, l);
    chk("abort_hi", h, 32'd0);
    chk("abort_lo", l, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
